// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: stage encodings, opcodes, the HALT trap word and
// the run-state type used by the stage sequencer.
package lc3_pkg;

  localparam logic [1:0] STG_DECODE    = 2'b00;
  localparam logic [1:0] STG_EXECUTE   = 2'b01;
  localparam logic [1:0] STG_WRITEBACK = 2'b10;
  localparam logic [1:0] STG_FETCH     = 2'b11;

  localparam logic [3:0] OP_TRAP = 4'hF;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;

  localparam logic [15:0] HALT_INSN = 16'hF025;

  typedef enum logic [1:0] {
    RS_IDLE    = 2'b00,
    RS_RUNNING = 2'b01,
    RS_HALTED  = 2'b10
  } run_state_e;

  function automatic logic [1:0] seq_next(input logic [1:0] stg);
    logic [1:0] nxt;
    case (stg)
      STG_FETCH:     nxt = STG_DECODE;
      STG_DECODE:    nxt = STG_EXECUTE;
      STG_EXECUTE:   nxt = STG_WRITEBACK;
      default:       nxt = STG_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic is_halt(input logic [15:0] ir);
    return (ir == HALT_INSN);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory stage has waited for MEM_RDY and flags
// the cycle in which the MAX_WAIT-th wait would be completed without ready.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready arriving in the limit cycle drops waiting, so it wins over expiry.
  assign expired = waiting && (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// LC-3 instruction stage sequencer with memory-ready stall, HALT and timeout.
// Define SEQ_INSN_COUNT_EN to build the retired-instruction counter.
//
// run state  | meaning
// RS_IDLE    | waiting for RUN, STAGE parked at FETCH, no requests
// RS_RUNNING | stepping stages, stalling on memory ready
// RS_HALTED  | stopped by HALT or memory timeout; left only by reset
module stage_sequencer import lc3_pkg::*; #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RUN,
  input  logic [15:0] IR,
  input  logic        MEM_OP,
  input  logic        MEM_RDY,
  input  logic        NEXT_STAGE_LE,
  input  logic [1:0]  NEXT_STAGE,
  output logic [1:0]  STAGE,
  output logic        ADVANCE,
  output logic        MEM_REQ,
  output logic        HALTED,
  output logic        FAULT,
  output logic [15:0] INSN_COUNT
);

  run_state_e run_q;
  logic [1:0] stage_q, stage_d;
  logic       halted_q;
  logic       fault_q;

  logic running;
  logic waiting;
  logic advance;
  logic halt_now;
  logic expired;

  assign running = (run_q == RS_RUNNING);
  assign MEM_REQ = running &&
                   ((stage_q == STG_FETCH) || ((stage_q == STG_WRITEBACK) && MEM_OP));
  assign waiting = MEM_REQ && !MEM_RDY;
  assign advance = running && !waiting;
  assign halt_now = (stage_q == STG_WRITEBACK) && is_halt(IR);

  always_comb begin
    stage_d = seq_next(stage_q);
    if (halt_now) begin
      stage_d = STG_FETCH;
    end else if (NEXT_STAGE_LE) begin
      stage_d = NEXT_STAGE;
    end
  end

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clear   (advance || !running),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q    <= RS_IDLE;
      stage_q  <= STG_FETCH;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (run_q)
        RS_IDLE: begin
          if (RUN) begin
            run_q <= RS_RUNNING;
          end
        end
        RS_RUNNING: begin
          if (expired) begin
            run_q    <= RS_HALTED;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
            stage_q  <= STG_FETCH;
          end else if (advance) begin
            stage_q <= stage_d;
            if (halt_now) begin
              run_q    <= RS_HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign STAGE   = stage_q;
  assign ADVANCE = advance;
  assign HALTED  = halted_q;
  assign FAULT   = fault_q;

`ifdef SEQ_INSN_COUNT_EN
  logic        retire;
  logic [15:0] count_q;

  // The HALT transition lands on FETCH, so it retires through the same term.
  assign retire = advance &&
                  ((stage_q == STG_EXECUTE) || (stage_q == STG_WRITEBACK)) &&
                  ((stage_d == STG_FETCH) || (stage_d == STG_DECODE));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign INSN_COUNT = count_q;
`else
  assign INSN_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed-vector bench for stage_sequencer: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_stage_sequencer;

  localparam logic [1:0] SD = 2'b00;
  localparam logic [1:0] SE = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SF = 2'b11;
  localparam logic [15:0] ADD_INSN  = 16'h1261;
  localparam logic [15:0] HALT_WORD = 16'hF025;

`ifdef SEQ_INSN_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        RUN = 1'b0;
  logic [15:0] IR = ADD_INSN;
  logic        MEM_OP = 1'b0;
  logic        MEM_RDY = 1'b0;
  logic        NEXT_STAGE_LE = 1'b0;
  logic [1:0]  NEXT_STAGE = 2'b00;
  logic [1:0]  STAGE;
  logic        ADVANCE;
  logic        MEM_REQ;
  logic        HALTED;
  logic        FAULT;
  logic [15:0] INSN_COUNT;

  stage_sequencer #(.MAX_WAIT(15)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .RUN           (RUN),
    .IR            (IR),
    .MEM_OP        (MEM_OP),
    .MEM_RDY       (MEM_RDY),
    .NEXT_STAGE_LE (NEXT_STAGE_LE),
    .NEXT_STAGE    (NEXT_STAGE),
    .STAGE         (STAGE),
    .ADVANCE       (ADVANCE),
    .MEM_REQ       (MEM_REQ),
    .HALTED        (HALTED),
    .FAULT         (FAULT),
    .INSN_COUNT    (INSN_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  stage;
    logic        adv;
    logic        req;
    logic        halted;
    logic        fault;
    logic [15:0] cnt;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass = 0;
  int   vec_id = 0;

  function automatic logic [15:0] ec(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %h, expected %h", name, id, act, exp);
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("STAGE",      int'(e.id), 16'(STAGE),   16'(e.stage));
      chk("ADVANCE",    int'(e.id), 16'(ADVANCE), 16'(e.adv));
      chk("MEM_REQ",    int'(e.id), 16'(MEM_REQ), 16'(e.req));
      chk("HALTED",     int'(e.id), 16'(HALTED),  16'(e.halted));
      chk("FAULT",      int'(e.id), 16'(FAULT),   16'(e.fault));
      chk("INSN_COUNT", int'(e.id), INSN_COUNT,   e.cnt);
    end
  end

  // Drive one cycle's inputs, queue what the outputs must show during it.
  task automatic cyc(input logic rdy, input logic le, input logic [1:0] ns,
                     input logic [1:0] es, input logic ea, input logic er,
                     input logic eh, input logic ef, input int n);
    exp_t e;
    MEM_RDY = rdy;
    NEXT_STAGE_LE = le;
    NEXT_STAGE = ns;
    e.stage = es;
    e.adv = ea;
    e.req = er;
    e.halted = eh;
    e.fault = ef;
    e.cnt = ec(n);
    e.id = 16'(vec_id);
    vec_id++;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Assert reset between edges and check outputs before any clock arrives.
  task automatic reset_check(input int id);
    RST_N = 1'b0;
    #1;
    chk("RST_STAGE",   id, 16'(STAGE),   16'(SF));
    chk("RST_ADVANCE", id, 16'(ADVANCE), 16'h0);
    chk("RST_MEM_REQ", id, 16'(MEM_REQ), 16'h0);
    chk("RST_HALTED",  id, 16'(HALTED),  16'h0);
    chk("RST_FAULT",   id, 16'(FAULT),   16'h0);
    chk("RST_COUNT",   id, INSN_COUNT,   16'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RUN = 1'b0;
    RST_N = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    #2;
    reset_check(0);

    // plain ADD, zero-wait memory
    IR = ADD_INSN;
    MEM_OP = 1'b0;
    cyc(1, 0, 2'b00, SF, 0, 0, 0, 0, 0);
    RUN = 1'b1;
    cyc(1, 0, 2'b00, SF, 0, 0, 0, 0, 0);
    RUN = 1'b0;
    cyc(1, 0, 2'b00, SF, 1, 1, 0, 0, 0);
    cyc(1, 0, 2'b00, SD, 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, SE, 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, SW, 1, 0, 0, 0, 0);

    // three-cycle FETCH stall; ready outside a request is ignored in DECODE
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, SF, 0, 1, 0, 0, 1);
    cyc(1, 0, 2'b00, SF, 1, 1, 0, 0, 1);
    cyc(0, 0, 2'b00, SD, 1, 0, 0, 0, 1);

    // skip requests: EXECUTE->DECODE retires, DECODE->DECODE does not
    cyc(1, 1, SD, SE, 1, 0, 0, 0, 1);
    cyc(1, 1, SD, SD, 1, 0, 0, 0, 2);
    cyc(1, 0, 2'b00, SD, 1, 0, 0, 0, 2);
    cyc(1, 1, SF, SE, 1, 0, 0, 0, 2);
    cyc(1, 1, SE, SF, 1, 1, 0, 0, 3);
    cyc(1, 0, 2'b00, SE, 1, 0, 0, 0, 3);

    // memory WRITEBACK with no wait; RUN while running is ignored
    MEM_OP = 1'b1;
    RUN = 1'b1;
    cyc(1, 0, 2'b00, SW, 1, 1, 0, 0, 3);
    RUN = 1'b0;

    // 14 waits then ready in the limit cycle: no fault
    cyc(1, 0, 2'b00, SF, 1, 1, 0, 0, 4);
    cyc(0, 0, 2'b00, SD, 1, 0, 0, 0, 4);
    cyc(0, 0, 2'b00, SE, 1, 0, 0, 0, 4);
    for (int i = 0; i < 14; i++) cyc(0, 0, 2'b00, SW, 0, 1, 0, 0, 4);
    cyc(1, 0, 2'b00, SW, 1, 1, 0, 0, 4);

    // 15 waits in WRITEBACK: timeout fault
    cyc(1, 0, 2'b00, SF, 1, 1, 0, 0, 5);
    cyc(1, 0, 2'b00, SD, 1, 0, 0, 0, 5);
    cyc(1, 0, 2'b00, SE, 1, 0, 0, 0, 5);
    for (int i = 0; i < 15; i++) cyc(0, 0, 2'b00, SW, 0, 1, 0, 0, 5);
    RUN = 1'b1;
    cyc(0, 0, 2'b00, SF, 0, 0, 1, 1, 5);
    cyc(1, 0, 2'b00, SF, 0, 0, 1, 1, 5);
    RUN = 1'b0;
    reset_check(1);

    // HALT wins over a skip request in WRITEBACK and retires
    IR = HALT_WORD;
    MEM_OP = 1'b0;
    RUN = 1'b1;
    cyc(1, 0, 2'b00, SF, 0, 0, 0, 0, 0);
    RUN = 1'b0;
    cyc(1, 0, 2'b00, SF, 1, 1, 0, 0, 0);
    cyc(1, 0, 2'b00, SD, 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, SE, 1, 0, 0, 0, 0);
    cyc(1, 1, SE, SW, 1, 0, 0, 0, 0);
    RUN = 1'b1;
    cyc(1, 0, 2'b00, SF, 0, 0, 1, 0, 1);
    RUN = 1'b0;
    cyc(1, 0, 2'b00, SF, 0, 0, 1, 0, 1);
    reset_check(2);

    // reset mid-wait in WRITEBACK
    IR = ADD_INSN;
    RUN = 1'b1;
    cyc(1, 0, 2'b00, SF, 0, 0, 0, 0, 0);
    RUN = 1'b0;
    cyc(1, 0, 2'b00, SF, 1, 1, 0, 0, 0);
    cyc(1, 0, 2'b00, SD, 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, SE, 1, 0, 0, 0, 0);
    MEM_OP = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, SW, 0, 1, 0, 0, 0);
    reset_check(3);
    MEM_OP = 1'b0;
    cyc(1, 0, 2'b00, SF, 0, 0, 0, 0, 0);

    @(posedge CLK);
    #1;
    chk("QUEUE_DRAINED", 4, 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
